// File: rtl/seq_mux_if.sv
// Bus bundle between a parallel source bank (master) and the seq_mux slave.
// Carries the per-cycle controls, the flattened channel data and the registered result.
interface seq_mux_if #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic                      en;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS*WIDTH-1:0] din;
  logic [WIDTH-1:0]          y;
  logic [SEL_W-1:0]          ch;
  logic                      valid;
  logic                      wrap;

  modport master (
    output en, mode, sel, din,
    input  y, ch, valid, wrap
  );

  modport slave (
    input  en, mode, sel, din,
    output y, ch, valid, wrap
  );
endinterface

// File: rtl/seq_mux.sv
// Registered N-channel multiplexer: direct select or round-robin scan with a per-channel dwell,
// a valid flag for legal fresh samples and a wrap pulse on the last sample of each rotation.
module seq_mux #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 1
) (
  input  logic     clk,
  input  logic     rst,
  seq_mux_if.slave bus
);

  localparam int                DCNT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0]  LAST_CH = SEL_W'(CHANNELS - 1);
  localparam logic [DCNT_W-1:0] LAST_DW = DCNT_W'(DWELL - 1);
  localparam logic [SEL_W:0]    NUM_CH  = (SEL_W + 1)'(CHANNELS);

  logic [WIDTH-1:0]  y_q,     y_d;
  logic [SEL_W-1:0]  ch_q,    ch_d;
  logic              valid_q, valid_d;
  logic              wrap_q,  wrap_d;
  logic [SEL_W-1:0]  ptr_q,   ptr_d;
  logic [DCNT_W-1:0] dcnt_q,  dcnt_d;
  logic              sel_legal;

  // Indices at or above CHANNELS select nothing and yield zero.
  function automatic logic [WIDTH-1:0] pick(
    input logic [CHANNELS*WIDTH-1:0] d,
    input logic [SEL_W-1:0]          idx
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) r = d[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  // Explicit wrap at CHANNELS-1 keeps the pointer legal for non-power-of-2 channel counts.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
    return (p == LAST_CH) ? '0 : p + SEL_W'(1);
  endfunction

  always_comb begin
    y_d       = y_q;
    ch_d      = ch_q;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;
    ptr_d     = ptr_q;
    dcnt_d    = dcnt_q;
    sel_legal = ({1'b0, bus.sel} < NUM_CH);
    if (bus.en) begin
      if (!bus.mode) begin
        ch_d    = bus.sel;
        y_d     = sel_legal ? pick(bus.din, bus.sel) : '0;
        valid_d = sel_legal;
        ptr_d   = '0;
        dcnt_d  = '0;
      end else begin
        y_d     = pick(bus.din, ptr_q);
        ch_d    = ptr_q;
        valid_d = 1'b1;
        if (dcnt_q == LAST_DW) begin
          dcnt_d = '0;
          ptr_d  = next_ptr(ptr_q);
          wrap_d = (ptr_q == LAST_CH);
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
    end
  end

  // Output and scan-state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      ptr_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      y_q     <= y_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      ptr_q   <= ptr_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.ch    = ch_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_seq_mux.sv
// Directed bench for seq_mux: a 4-channel DWELL=1 instance and a 3-channel DWELL=3 instance,
// driven from vector tables, plus a hand sequence for asynchronous reset during a scan.
module tb_seq_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b0;
  logic rst1 = 1'b0;

  seq_mux_if #(.WIDTH(2), .CHANNELS(4), .SEL_W(2)) bus0 ();
  seq_mux_if #(.WIDTH(2), .CHANNELS(3), .SEL_W(2)) bus1 ();

  seq_mux #(.WIDTH(2), .CHANNELS(4), .SEL_W(2), .DWELL(1)) dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0)
  );

  seq_mux #(.WIDTH(2), .CHANNELS(3), .SEL_W(2), .DWELL(3)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  typedef struct {
    logic       en;
    logic       mode;
    logic [1:0] sel;
    logic [1:0] y;
    logic [1:0] ch;
    logic       valid;
    logic       wrap;
    string      name;
  } vec_t;

  vec_t tab0[$];
  vec_t tab1[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int which, input logic en, input logic mode, input logic [1:0] sel,
                     input logic [1:0] y, input logic [1:0] ch, input logic valid,
                     input logic wrap, input string name);
    vec_t t;
    t = '{en, mode, sel, y, ch, valid, wrap, name};
    if (which == 0) tab0.push_back(t);
    else            tab1.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk0(input string nm, input logic [1:0] y, input logic [1:0] ch,
                      input logic v, input logic w);
    chk({nm, ".y"},     32'(bus0.y),     32'(y));
    chk({nm, ".ch"},    32'(bus0.ch),    32'(ch));
    chk({nm, ".valid"}, 32'(bus0.valid), 32'(v));
    chk({nm, ".wrap"},  32'(bus0.wrap),  32'(w));
  endtask

  task automatic chk1(input string nm, input logic [1:0] y, input logic [1:0] ch,
                      input logic v, input logic w);
    chk({nm, ".y"},     32'(bus1.y),     32'(y));
    chk({nm, ".ch"},    32'(bus1.ch),    32'(ch));
    chk({nm, ".valid"}, 32'(bus1.valid), 32'(v));
    chk({nm, ".wrap"},  32'(bus1.wrap),  32'(w));
  endtask

  initial begin
    // 4 channels: ch3=10, ch2=11, ch1=01, ch0=00
    add(0, 1, 0, 2'd1, 2'b01, 2'd1, 1, 0, "dir_sel1");
    add(0, 1, 0, 2'd3, 2'b10, 2'd3, 1, 0, "dir_sel3");
    add(0, 1, 0, 2'd2, 2'b11, 2'd2, 1, 0, "dir_sel2");
    add(0, 1, 1, 2'd2, 2'b00, 2'd0, 1, 0, "scan0");
    add(0, 1, 1, 2'd2, 2'b01, 2'd1, 1, 0, "scan1");
    add(0, 1, 1, 2'd2, 2'b11, 2'd2, 1, 0, "scan2");
    add(0, 1, 1, 2'd2, 2'b10, 2'd3, 1, 1, "scan3");
    add(0, 1, 1, 2'd2, 2'b00, 2'd0, 1, 0, "scan4");
    add(0, 1, 1, 2'd2, 2'b01, 2'd1, 1, 0, "scan5");
    add(0, 1, 1, 2'd2, 2'b11, 2'd2, 1, 0, "scan6");
    add(0, 1, 1, 2'd2, 2'b10, 2'd3, 1, 1, "scan7");
    add(0, 1, 1, 2'd2, 2'b00, 2'd0, 1, 0, "scan8");
    add(0, 1, 1, 2'd0, 2'b01, 2'd1, 1, 0, "pre_stall");
    add(0, 0, 1, 2'd3, 2'b01, 2'd1, 0, 0, "stall_a");
    add(0, 0, 0, 2'd3, 2'b01, 2'd1, 0, 0, "stall_b");
    add(0, 1, 1, 2'd3, 2'b11, 2'd2, 1, 0, "post_stall");
    add(0, 1, 0, 2'd0, 2'b00, 2'd0, 1, 0, "to_direct");
    add(0, 1, 1, 2'd3, 2'b00, 2'd0, 1, 0, "rescan0");
    add(0, 1, 1, 2'd3, 2'b01, 2'd1, 1, 0, "rescan1");
    add(0, 1, 1, 2'd3, 2'b11, 2'd2, 1, 0, "rescan2");
    add(0, 1, 1, 2'd3, 2'b10, 2'd3, 1, 1, "rescan3");
    add(0, 0, 1, 2'd3, 2'b10, 2'd3, 0, 0, "wrap_stall");
    add(0, 1, 1, 2'd3, 2'b00, 2'd0, 1, 0, "after_wrap");

    // 3 channels, DWELL=3: ch2=11, ch1=10, ch0=01
    add(1, 1, 1, 2'd0, 2'b01, 2'd0, 1, 0, "d3_0a");
    add(1, 1, 1, 2'd0, 2'b01, 2'd0, 1, 0, "d3_0b");
    add(1, 1, 1, 2'd0, 2'b01, 2'd0, 1, 0, "d3_0c");
    add(1, 1, 1, 2'd0, 2'b10, 2'd1, 1, 0, "d3_1a");
    add(1, 1, 1, 2'd0, 2'b10, 2'd1, 1, 0, "d3_1b");
    add(1, 1, 1, 2'd0, 2'b10, 2'd1, 1, 0, "d3_1c");
    add(1, 1, 1, 2'd3, 2'b11, 2'd2, 1, 0, "d3_2a");
    add(1, 1, 1, 2'd3, 2'b11, 2'd2, 1, 0, "d3_2b");
    add(1, 1, 1, 2'd3, 2'b11, 2'd2, 1, 1, "d3_2c");
    add(1, 1, 1, 2'd3, 2'b01, 2'd0, 1, 0, "d3_wrap0");
    add(1, 0, 1, 2'd0, 2'b01, 2'd0, 0, 0, "d3_stall_a");
    add(1, 0, 1, 2'd0, 2'b01, 2'd0, 0, 0, "d3_stall_b");
    add(1, 1, 1, 2'd0, 2'b01, 2'd0, 1, 0, "d3_resume_b");
    add(1, 1, 1, 2'd0, 2'b01, 2'd0, 1, 0, "d3_resume_c");
    add(1, 1, 1, 2'd0, 2'b10, 2'd1, 1, 0, "d3_resume_1");
    add(1, 1, 0, 2'd3, 2'b00, 2'd3, 0, 0, "illegal_sel");
    add(1, 1, 0, 2'd2, 2'b11, 2'd2, 1, 0, "legal_sel2");
    add(1, 1, 1, 2'd3, 2'b01, 2'd0, 1, 0, "d3_restart_a");
    add(1, 1, 1, 2'd3, 2'b01, 2'd0, 1, 0, "d3_restart_b");

    bus0.en = 1'b0; bus0.mode = 1'b0; bus0.sel = '0; bus0.din = 8'b10_11_01_00;
    bus1.en = 1'b0; bus1.mode = 1'b0; bus1.sel = '0; bus1.din = 6'b11_10_01;

    #1 rst0 = 1'b1; rst1 = 1'b1;
    #1;
    chk0("reset0", 2'b00, 2'd0, 1'b0, 1'b0);
    chk1("reset1", 2'b00, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;

    foreach (tab0[i]) begin
      bus0.en   = tab0[i].en;
      bus0.mode = tab0[i].mode;
      bus0.sel  = tab0[i].sel;
      step();
      chk0(tab0[i].name, tab0[i].y, tab0[i].ch, tab0[i].valid, tab0[i].wrap);
    end

    // Async reset between edges while presenting channel 2
    bus0.en = 1'b1; bus0.mode = 1'b1;
    step();
    chk0("pre_rst1", 2'b01, 2'd1, 1'b1, 1'b0);
    step();
    chk0("pre_rst2", 2'b11, 2'd2, 1'b1, 1'b0);
    #2 rst0 = 1'b1;
    #1;
    chk0("async_rst", 2'b00, 2'd0, 1'b0, 1'b0);
    #1 rst0 = 1'b0;
    step();
    chk0("post_rst0", 2'b00, 2'd0, 1'b1, 1'b0);
    step();
    chk0("post_rst1", 2'b01, 2'd1, 1'b1, 1'b0);
    bus0.en = 1'b0;

    foreach (tab1[i]) begin
      bus1.en   = tab1[i].en;
      bus1.mode = tab1[i].mode;
      bus1.sel  = tab1[i].sel;
      step();
      chk1(tab1[i].name, tab1[i].y, tab1[i].ch, tab1[i].valid, tab1[i].wrap);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mux.md
# seq_mux

Parametrised, registered N-channel multiplexer with direct-select and auto-scan modes. It generalises the team's combinational 4:1, 2-bit case multiplexer to arbitrary data width and channel count. It adds a registered output with a valid flag, an internal round-robin scan pointer with a programmable dwell time, and a wrap pulse. It sits between a bank of parallel sources and a single downstream consumer, such as a display driver or a serial packer.

## Interface
- WIDTH, 2, data width per channel
- CHANNELS, 4, number of input channels (≥2; need not be a power of 2)
- SEL_W, 2, select/pointer width; must satisfy 2^SEL_W ≥ CHANNELS
- DWELL, 1, enabled cycles spent on each channel in scan mode (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  sample enable; outputs update only on cycles where en=1
- mode  in  1  0 = direct select, 1 = auto-scan
- sel  in  SEL_W  channel select, used in direct mode only
- din  in  CHANNELS*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH]
- y  out  WIDTH  registered selected data
- ch  out  SEL_W  index of the channel currently presented on y
- valid  out  1  y/ch hold a fresh, legal sample from this cycle's update
- wrap  out  1  one-cycle pulse on the final dwell sample of channel CHANNELS-1 in scan mode

## Operation
- Reset (async, any time): y=0, ch=0, valid=0, wrap=0, internal ptr=0, dwell count dcnt=0.
- en=0: y and ch hold; valid←0; wrap←0; ptr and dcnt hold.
- Direct mode (mode=0, en=1):
  - sel<CHANNELS: y←din[sel], ch←sel, valid←1.
  - sel≥CHANNELS: y←0, ch←sel, valid←0.
  - wrap←0. ptr←0 and dcnt←0 every direct-mode cycle, so scan always restarts at channel 0.
- Scan mode (mode=1, en=1):
  - y←din[ptr], ch←ptr, valid←1.
  - If dcnt==DWELL-1: dcnt←0 and ptr←(ptr==CHANNELS-1 ? 0 : ptr+1); wrap←1 iff ptr==CHANNELS-1.
  - Otherwise: dcnt←dcnt+1, ptr holds, wrap←0.
  - sel is ignored.
- Pointer states: 0 → 1 → … → CHANNELS-1 → 0. It never enters values ≥CHANNELS, including when CHANNELS is not a power of 2.
- Switching mode 1→0 mid-dwell: the next enabled cycle is a direct sample, and ptr/dcnt clear. Switching 0→1: the first scan sample is channel 0 with dcnt=0.
- din is sampled at the clock edge; no combinational path from din/sel to any output.

## Timing
- Latency: 1 clock from the en=1 edge to the updated y/ch/valid/wrap.
- Throughput: one sample per enabled cycle.
- Scan period: CHANNELS*DWELL enabled cycles per full rotation. wrap fires once per rotation, coincident with the final ch=CHANNELS-1 sample.
- Stalls (en=0) freeze the scan position without losing dwell progress.
- Reset deassertion: the first enabled edge after reset produces channel 0 (scan) or din[sel] (direct).

## Test plan
- Direct, defaults: en=1, mode=0, din={d=2'b10, c=2'b11, b=2'b01, a=2'b00} (channel 3 down to 0), sel=2'b01 → next cycle y=2'b01, ch=1, valid=1. Then sel=2'b11 → y=2'b10, ch=3.
- Scan, DWELL=1: mode=1, en=1 held for 9 cycles, same din → ch sequence 0,1,2,3,0,1,2,3,0; y=00,01,11,10,…; wrap high only on the two ch=3 cycles.
- Scan, DWELL=3, CHANNELS=3, SEL_W=2: → ch=0,0,0,1,1,1,2,2,2,0; wrap high only on the third ch=2 cycle; ch never reaches 3.
- Stall and mode switch: in scan with DWELL=1, drop en for 2 cycles after ch=1 → y/ch hold, valid=0. Raise en → ch=2. Then mode=0, sel=0 → ch=0. Then mode=1 → scan restarts at ch=0.
- Illegal select: CHANNELS=3, mode=0, sel=2'b11 → y=0, ch=3, valid=0, wrap=0.
- Async reset mid-scan: assert rst between edges while ch=2 → y=0, ch=0, valid=0, wrap=0 immediately, with no clock edge required. After release → first scan sample is ch=0.
